// File: rtl/m_useq_pkg.sv
// Shared ARC microsequencer definitions: COND encodings, MIR field offsets,
// sequencer state codes and the dispatch-address helper.
`timescale 1ns/1ps
package m_useq_pkg;

  localparam int CS_AW = 11;
  localparam logic [CS_AW-1:0] RESET_ADDR_DEF = 11'd0;

  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  localparam int MIR_JADDR_LSB = 0;
  localparam int MIR_JADDR_MSB = 10;
  localparam int MIR_COND_LSB  = 11;
  localparam int MIR_COND_MSB  = 13;
  localparam int MIR_WR_BIT    = 14;
  localparam int MIR_RD_BIT    = 15;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Opcode dispatch: 1, op, op3, 00 -- four microwords per instruction.
  function automatic logic [CS_AW-1:0] decode_addr(input logic [31:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/m_useq_br_cond.sv
// Branch-condition mux: selects the flag/IR bit named by COND and forms the
// opcode dispatch address.
`timescale 1ns/1ps
module m_br_cond
  import m_useq_pkg::*;
(
  input  logic [2:0]       cond,
  input  logic             psr_n,
  input  logic             psr_z,
  input  logic             psr_v,
  input  logic             psr_c,
  input  logic [31:0]      ir,
  output logic             taken,
  output logic [CS_AW-1:0] dec_addr
);

  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[29:25], ir[18:14], ir[12:0]};

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NEXT:   taken = 1'b0;
      COND_N:      taken = psr_n;
      COND_Z:      taken = psr_z;
      COND_V:      taken = psr_v;
      COND_C:      taken = psr_c;
      COND_IR13:   taken = ir[13];
      COND_JUMP:   taken = 1'b1;
      COND_DECODE: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  assign dec_addr = decode_addr(ir);

endmodule

// File: rtl/m_useq.sv
// ARC microsequencer: control-store address register with memory-wait stall
// and debug halt/single-step.
//
// state    | meaning
// ST_RESET | one cycle after reset, address pinned at RESET_ADDR
// ST_RUN   | advance to next_addr every cycle
// ST_WAIT  | RD/WR outstanding, address frozen until mem_rdy
// ST_HALT  | debug halt, advance only on step
`timescale 1ns/1ps
module m_useq
  import m_useq_pkg::*;
#(
  parameter int            AW         = CS_AW,
  parameter logic [AW-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cond,
  input  logic [AW-1:0] jump_addr,
  input  logic          mir_rd,
  input  logic          mir_wr,
  input  logic          mem_rdy,
  input  logic          psr_n,
  input  logic          psr_z,
  input  logic          psr_v,
  input  logic          psr_c,
  input  logic [31:0]   ir,
  input  logic          halt,
  input  logic          step,
  output logic [AW-1:0] cs_addr,
  output logic          busy_mem,
  output logic          halted
);

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] addr_nxt, next_addr;
  logic          taken;
  logic [AW-1:0] dec_addr;
  logic          mem_pend;

  m_br_cond u_br_cond (
    .cond     (cond),
    .psr_n    (psr_n),
    .psr_z    (psr_z),
    .psr_v    (psr_v),
    .psr_c    (psr_c),
    .ir       (ir),
    .taken    (taken),
    .dec_addr (dec_addr)
  );

  // Increment wraps naturally at the top of the control store.
  always_comb begin
    if (cond == COND_DECODE) next_addr = dec_addr;
    else if (taken)          next_addr = jump_addr;
    else                     next_addr = cs_addr + {{(AW-1){1'b0}}, 1'b1};
  end

  // RD and WR together are one access; a single mem_rdy retires it.
  assign mem_pend = (mir_rd | mir_wr) & ~mem_rdy;

  always_comb begin
    state_nxt = state;
    addr_nxt  = cs_addr;
    case (state)
      ST_RESET: begin
        state_nxt = ST_RUN;
        addr_nxt  = RESET_ADDR;
      end
      ST_RUN: begin
        if (mem_pend)  state_nxt = ST_WAIT;
        else if (halt) state_nxt = ST_HALT;
        else           addr_nxt  = next_addr;
      end
      ST_WAIT: begin
        if (mem_rdy) begin
          addr_nxt  = next_addr;
          state_nxt = halt ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        if (!halt)                 state_nxt = ST_RUN;
        else if (step && !mem_pend) addr_nxt = next_addr;
      end
      default: begin
        state_nxt = ST_RESET;
        addr_nxt  = RESET_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      cs_addr <= RESET_ADDR;
    end else begin
      state   <= state_nxt;
      cs_addr <= addr_nxt;
    end
  end

  assign busy_mem = (state == ST_WAIT);
  assign halted   = (state == ST_HALT);

endmodule

// File: tb/tb_m_useq.sv
// Self-checking bench for m_useq: vector table for branch/increment/access
// cases plus directed wait, halt/step and mid-wait reset sequences.
`timescale 1ns/1ps
module tb_m_useq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cond;
  logic [10:0] jump_addr;
  logic        mir_rd, mir_wr, mem_rdy;
  logic        psr_n, psr_z, psr_v, psr_c;
  logic [31:0] ir;
  logic        halt, step;
  logic [10:0] cs_addr;
  logic        busy_mem, halted;

  int n_pass  = 0;
  int n_total = 0;

  m_useq dut (
    .clk       (clk),
    .rst       (rst),
    .cond      (cond),
    .jump_addr (jump_addr),
    .mir_rd    (mir_rd),
    .mir_wr    (mir_wr),
    .mem_rdy   (mem_rdy),
    .psr_n     (psr_n),
    .psr_z     (psr_z),
    .psr_v     (psr_v),
    .psr_c     (psr_c),
    .ir        (ir),
    .halt      (halt),
    .step      (step),
    .cs_addr   (cs_addr),
    .busy_mem  (busy_mem),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  cond;
    logic [10:0] ja;
    logic        rd, wr, rdy;
    logic        n, z, v, c;
    logic [31:0] ir;
    logic [10:0] exp_addr;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input string name, input logic [2:0] cnd, input logic [10:0] ja,
                              input logic rd, input logic wr, input logic rdy,
                              input logic n, input logic z, input logic v, input logic c,
                              input logic [31:0] irv, input logic [10:0] ea, input logic eb);
    vec_t t;
    t.name = name; t.cond = cnd; t.ja = ja; t.rd = rd; t.wr = wr; t.rdy = rdy;
    t.n = n; t.z = z; t.v = v; t.c = c; t.ir = irv; t.exp_addr = ea; t.exp_busy = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [10:0] ea, input logic eb, input logic eh);
    n_total++;
    if (cs_addr === ea && busy_mem === eb && halted === eh) n_pass++;
    else $display("FAIL %s: got cs_addr=%h busy_mem=%b halted=%b, want cs_addr=%h busy_mem=%b halted=%b",
                  name, cs_addr, busy_mem, halted, ea, eb, eh);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    cond = 3'b000; jump_addr = '0; mir_rd = 0; mir_wr = 0; mem_rdy = 0;
    psr_n = 0; psr_z = 0; psr_v = 0; psr_c = 0; ir = '0; halt = 0; step = 0;
  endtask

  initial begin
    clr_in();
    #1;
    chk("reset_async", 11'h000, 0, 0);
    tick(); tick();
    chk("reset_held", 11'h000, 0, 0);
    rst = 0;
    tick();
    chk("reset_state_exit", 11'h000, 0, 0);

    //            name           cond    ja        rd wr rdy n  z  v  c  ir            exp      busy
    vecs[0]  = mk("jump_7ff",    3'b110, 11'h7FF,  0, 0, 0, 0, 0, 0, 0, 32'h0,        11'h7FF, 0);
    vecs[1]  = mk("wrap",        3'b000, 11'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0,        11'h000, 0);
    vecs[2]  = mk("jump_1600",   3'b110, 11'd1600, 0, 0, 0, 0, 0, 0, 0, 32'h0,        11'd1600, 0);
    vecs[3]  = mk("jump_20a",    3'b110, 11'd20,   0, 0, 0, 0, 0, 0, 0, 32'h0,        11'd20,  0);
    vecs[4]  = mk("z_taken",     3'b010, 11'd40,   0, 0, 0, 0, 1, 0, 0, 32'h0,        11'd40,  0);
    vecs[5]  = mk("jump_20b",    3'b110, 11'd20,   0, 0, 0, 0, 0, 0, 0, 32'h0,        11'd20,  0);
    vecs[6]  = mk("z_not",       3'b010, 11'd40,   0, 0, 0, 1, 0, 1, 1, 32'h0,        11'd21,  0);
    vecs[7]  = mk("n_taken",     3'b001, 11'd40,   0, 0, 0, 1, 0, 0, 0, 32'h0,        11'd40,  0);
    vecs[8]  = mk("jump_20c",    3'b110, 11'd20,   0, 0, 0, 0, 0, 0, 0, 32'h0,        11'd20,  0);
    vecs[9]  = mk("n_not",       3'b001, 11'd40,   0, 0, 0, 0, 1, 1, 1, 32'h0,        11'd21,  0);
    vecs[10] = mk("v_taken",     3'b011, 11'd100,  0, 0, 0, 0, 0, 1, 0, 32'h0,        11'd100, 0);
    vecs[11] = mk("v_not",       3'b011, 11'd300,  0, 0, 0, 1, 1, 0, 1, 32'h0,        11'd101, 0);
    vecs[12] = mk("c_taken",     3'b100, 11'd300,  0, 0, 0, 0, 0, 0, 1, 32'h0,        11'd300, 0);
    vecs[13] = mk("c_not",       3'b100, 11'd500,  0, 0, 0, 1, 1, 1, 0, 32'h0,        11'd301, 0);
    vecs[14] = mk("ir13_taken",  3'b101, 11'd500,  0, 0, 0, 0, 0, 0, 0, 32'h0000_2000, 11'd500, 0);
    vecs[15] = mk("ir13_not",    3'b101, 11'd900,  0, 0, 0, 1, 1, 1, 1, 32'hFFFF_DFFF, 11'd501, 0);
    vecs[16] = mk("decode_660",  3'b111, 11'd7,    0, 0, 0, 0, 0, 0, 0, 32'h80C0_2001, 11'h660, 0);
    vecs[17] = mk("decode_600",  3'b111, 11'd7,    0, 0, 0, 0, 0, 0, 0, 32'h8600_2001, 11'h600, 0);
    vecs[18] = mk("next_ign_jmp",3'b000, 11'd40,   0, 0, 0, 1, 1, 1, 1, 32'hFFFF_FFFF, 11'h601, 0);
    vecs[19] = mk("rd_zero_stall",3'b000, 11'd0,   1, 0, 1, 0, 0, 0, 0, 32'h0,        11'h602, 0);
    vecs[20] = mk("rdwr_stall",  3'b000, 11'd0,    1, 1, 0, 0, 0, 0, 0, 32'h0,        11'h602, 1);
    vecs[21] = mk("rdwr_done",   3'b000, 11'd0,    1, 1, 1, 0, 0, 0, 0, 32'h0,        11'h603, 0);

    for (int i = 0; i < 22; i++) begin
      cond = vecs[i].cond; jump_addr = vecs[i].ja;
      mir_rd = vecs[i].rd; mir_wr = vecs[i].wr; mem_rdy = vecs[i].rdy;
      psr_n = vecs[i].n; psr_z = vecs[i].z; psr_v = vecs[i].v; psr_c = vecs[i].c;
      ir = vecs[i].ir;
      tick();
      chk(vecs[i].name, vecs[i].exp_addr, vecs[i].exp_busy, 0);
    end
    clr_in();

    // Read stalled for three cycles, then completes and advances by one.
    cond = 3'b110; jump_addr = 11'd10; tick(); chk("seq_wait_setup", 11'd10, 0, 0);
    cond = 3'b000; mir_rd = 1; mem_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("seq_wait_hold", 11'd10, 1, 0);
    end
    mem_rdy = 1; tick(); chk("seq_wait_done", 11'd11, 0, 0);

    // Halt raised while waiting: access completes, address advances, lands in HALT.
    mem_rdy = 0; tick(); chk("seq_wait2", 11'd11, 1, 0);
    halt = 1; mem_rdy = 1; tick(); chk("seq_wait_to_halt", 11'd12, 0, 1);
    mir_rd = 0; mem_rdy = 0; tick(); chk("seq_halt_hold0", 11'd12, 0, 1);
    halt = 0; tick(); chk("seq_halt_release0", 11'd12, 0, 0);

    // Halt at 5, two steps, pending access blocks a step, then resume.
    cond = 3'b110; jump_addr = 11'd5; tick(); chk("seq_halt_setup", 11'd5, 0, 0);
    cond = 3'b000; halt = 1;
    tick(); chk("seq_halt_enter", 11'd5, 0, 1);
    tick(); chk("seq_halt_hold", 11'd5, 0, 1);
    step = 1; tick(); chk("seq_step1", 11'd6, 0, 1);
    step = 0; tick(); chk("seq_step_gap", 11'd6, 0, 1);
    step = 1; tick(); chk("seq_step2", 11'd7, 0, 1);
    step = 1; mir_rd = 1; mem_rdy = 0; tick(); chk("seq_step_blocked", 11'd7, 0, 1);
    step = 0; mir_rd = 0; halt = 0; tick(); chk("seq_halt_exit", 11'd7, 0, 0);
    tick(); chk("seq_resume", 11'd8, 0, 0);

    // Reset pulse in the middle of a WAIT at address 12.
    cond = 3'b110; jump_addr = 11'd12; tick(); chk("seq_rst_setup", 11'd12, 0, 0);
    cond = 3'b000; mir_rd = 1; mem_rdy = 0; tick(); chk("seq_rst_wait", 11'd12, 1, 0);
    #2 rst = 1;
    #1 chk("seq_rst_immediate", 11'd0, 0, 0);
    rst = 0; mir_rd = 0;
    tick(); chk("seq_rst_reset_state", 11'd0, 0, 0);
    tick(); chk("seq_rst_run", 11'd1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
